// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_pkg
//  Description : Shared types and constants for the USB full-speed transmit
//                line encoder. Contents:
//                  tx_state_t   encoder FSM state
//                  SYNC_BYTE    SYNC pattern, sent LSB-first
//                  STUFF_LIMIT  number of consecutive ones that forces a
//                               stuffed zero
//                  LINE_*       {d_plus, d_minus} line states
//                  nrzi_next()  NRZI line update for one bit
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_STUFF   = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // Line states are packed as {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // A 1 holds the line, a 0 flips J<->K.
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
    if (bit_val) begin
      return line;
    end
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_bit_timer
//  Description : Free-running USB bit-time counter. Counts 0..CLKS_PER_BIT-1
//                and flags the last clock of every bit time.
//  Ports       : clk        in  system clock
//                rst        in  synchronous reset, active-high
//                restart    in  force the count back to zero (start of a bit)
//                bit_strobe out high for the final clk of each bit time
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_strobe
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_count <= '0;
    end else if (r_count == LAST_CNT) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bit_strobe = (r_count == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_encoder
//  Description : USB full-speed transmit line encoder. Takes packet bytes over
//                a valid/ready handshake, prepends SYNC, serialises LSB-first
//                with bit stuffing and NRZI, and closes each packet with EOP
//                (SE0 for two bit times, then J for one).
//  Ports       : clk       in   system clock
//                rst       in   synchronous reset, active-high
//                tx_data   in   8  packet byte (SYNC excluded)
//                tx_valid  in   tx_data valid
//                tx_last   in   tx_data is the final byte of the packet
//                tx_ready  out  byte accepted on edge where valid & ready
//                d_plus    out  encoded D+
//                d_minus   out  encoded D-
//                tx_busy   out  packet in progress (first accept .. EOP J end)
//                tx_error  out  one-clk pulse on underrun abort
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_error
);

  tx_state_t  r_state;
  tx_state_t  w_next_state;

  // Byte currently on the wire (bit 0 is the bit being sent) and the
  // byte waiting behind it; each carries its own tx_last flag.
  logic [7:0] r_shift;
  logic       r_shift_last;
  logic [7:0] r_hold;
  logic       r_hold_last;
  logic       r_hold_full;

  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_next;
  logic [2:0] r_ones;
  logic [1:0] r_line;
  logic [1:0] w_line_next;
  logic       r_ready_en;
  logic       r_error;

  logic       w_strobe;
  logic       w_accept;
  logic       w_start;
  logic       w_shift;
  logic       w_emit;
  logic       w_bit;
  logic       w_error;
  logic       w_data_adv;
  logic       w_load_hold;
  logic       w_eop_state;

  usb_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .restart    (w_start),
    .bit_strobe (w_strobe)
  );

  // --------------------------------------------------------------------------
  // Load decisions are kept out of the FSM block: tx_ready depends on them and
  // the FSM block depends on tx_ready through w_accept.
  // --------------------------------------------------------------------------
  // Data advances at a bit boundary unless six ones demand a stuffed zero.
  // In ST_STUFF the counter was just cleared by the stuffed bit.
  assign w_data_adv = w_strobe
                   && ((r_state == ST_DATA) || (r_state == ST_STUFF))
                   && (r_ones != STUFF_LIMIT);

  assign w_load_hold = w_strobe && (r_bit_cnt == 3'd7)
                    && ((r_state == ST_SYNC)
                        || (w_data_adv && !r_shift_last && r_hold_full));

  assign w_accept = tx_valid && tx_ready;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and per-bit control. Everything except the IDLE start
  // happens only on a bit boundary, so each line state lasts one bit time.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_line_next    = r_line;
    w_start        = 1'b0;
    w_shift        = 1'b0;
    w_emit         = 1'b0;
    w_bit          = 1'b0;
    w_error        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // A byte may already sit in hold if it arrived while the previous
        // packet's final byte was shifting out; it starts the next packet.
        if (w_accept || r_hold_full) begin
          w_next_state   = ST_SYNC;
          w_start        = 1'b1;
          w_emit         = 1'b1;
          w_bit          = SYNC_BYTE[0];
          w_bit_cnt_next = 3'd0;
        end
      end

      ST_SYNC: begin
        if (w_strobe) begin
          w_emit = 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_next_state   = ST_DATA;
            w_bit          = r_hold[0];
            w_bit_cnt_next = 3'd0;
          end else begin
            w_shift        = 1'b1;
            w_bit          = r_shift[1];
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
      end

      ST_DATA, ST_STUFF: begin
        if (w_strobe) begin
          if (!w_data_adv) begin
            // Stuffing is checked first so a stuff bit after a byte's
            // final bit goes out before EOP or the next byte.
            w_next_state = ST_STUFF;
            w_emit       = 1'b1;
            w_bit        = 1'b0;
          end else if (r_bit_cnt != 3'd7) begin
            w_next_state   = ST_DATA;
            w_shift        = 1'b1;
            w_emit         = 1'b1;
            w_bit          = r_shift[1];
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end else if (w_load_hold) begin
            w_next_state   = ST_DATA;
            w_emit         = 1'b1;
            w_bit          = r_hold[0];
            w_bit_cnt_next = 3'd0;
          end else begin
            // Either the last byte finished or the source ran dry (abort).
            w_next_state   = ST_EOP_SE0;
            w_line_next    = LINE_SE0;
            w_bit_cnt_next = 3'd0;
            w_error        = !r_shift_last;
          end
        end
      end

      ST_EOP_SE0: begin
        if (w_strobe) begin
          if (r_bit_cnt == 3'd0) begin
            w_bit_cnt_next = 3'd1;
          end else begin
            w_next_state   = ST_EOP_J;
            w_line_next    = LINE_J;
            w_bit_cnt_next = 3'd0;
          end
        end
      end

      ST_EOP_J: begin
        if (w_strobe) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
        w_line_next  = LINE_J;
      end
    endcase

    if (w_emit) begin
      w_line_next = nrzi_next(r_line, w_bit);
    end
  end

  // --------------------------------------------------------------------------
  // FSM outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_eop_state = (r_state == ST_EOP_SE0) || (r_state == ST_EOP_J);
    tx_busy     = (r_state != ST_IDLE);
    // A new byte may enter hold on the same edge hold drains into shift.
    tx_ready    = r_ready_en && !w_eop_state && (!r_hold_full || w_load_hold);
  end

  // --------------------------------------------------------------------------
  // Datapath: shift/hold registers, ones counter, line register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= 8'h00;
      r_shift_last <= 1'b0;
      r_hold       <= 8'h00;
      r_hold_last  <= 1'b0;
      r_hold_full  <= 1'b0;
      r_bit_cnt    <= 3'd0;
      r_ones       <= 3'd0;
      r_line       <= LINE_J;
      r_ready_en   <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_error    <= w_error;
      r_bit_cnt  <= w_bit_cnt_next;
      r_line     <= w_line_next;

      if (w_start) begin
        r_shift      <= SYNC_BYTE;
        r_shift_last <= 1'b0;
      end else if (w_load_hold) begin
        r_shift      <= r_hold;
        r_shift_last <= r_hold_last;
      end else if (w_shift) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end

      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_last <= tx_last;
        r_hold_full <= 1'b1;
      end else if (w_load_hold) begin
        r_hold_full <= 1'b0;
      end

      if (w_start) begin
        r_ones <= 3'd0;
      end else if (w_emit) begin
        r_ones <= w_bit ? (r_ones + 3'd1) : 3'd0;
      end
    end
  end

  assign d_plus   = r_line[1];
  assign d_minus  = r_line[0];
  assign tx_error = r_error;

endmodule
`default_nettype wire
